// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the rr_arb_mux channel multiplexer.
package rr_arb_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Producer/consumer bundle of rr_arb_mux; slave is the mux side, master the environment side.
interface rr_arb_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic                     force_en;
    logic [SEL_W-1:0]         force_sel;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// One-hot arbiter over NUM_CH requests: round-robin from ptr, or fixed lowest-index priority.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] idx;
    logic             found;
    int               base;

    // Scan NUM_CH candidates starting at base; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        base      = (ARB_MODE == ARB_FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < NUM_CH; k++) begin
            idx = SEL_W'((base + k) % NUM_CH);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= SEL_W'(next_idx(int'(grant_idx), NUM_CH));
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 arbitrated channel mux with valid/ready handshake and a registered output word.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int SEL_W    = $clog2(NUM_CH),
    parameter int ARB_MODE = ARB_RR
) (
    input logic         clk,
    input logic         rst,
    rr_arb_mux_if.slave bus
);

    logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]             elig;
    logic [NUM_CH-1:0]             grant;
    logic [SEL_W-1:0]              grant_idx;
    logic                          ld;
    logic                          xfer;
    logic                          advance;
    logic [DATA_W-1:0]             data_q;
    logic [SEL_W-1:0]              sel_q;
    logic                          valid_q;

    assign ch_data = bus.in_data;
    assign ld      = !valid_q || bus.out_ready;

    // An out-of-range force_sel matches no channel, so nothing is eligible.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++)
            elig[i] = bus.in_valid[i] && (!bus.force_en || bus.force_sel == SEL_W'(i));
    end

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (elig),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.in_ready = (ld && !rst) ? grant : '0;
    assign xfer         = ld && !rst && (|grant);
    assign advance      = xfer && (ARB_MODE == ARB_RR) && !bus.force_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else if (ld) begin
            valid_q <= |grant;
            if (|grant) begin
                data_q <= ch_data[grant_idx];
                sel_q  <= grant_idx;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed + random bench for rr_arb_mux; a round-robin and a fixed-priority instance share stimulus.
module tb_rr_arb_mux;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [N*W-1:0] din;
    logic [N-1:0] vin;
    logic         fen;
    logic [1:0]   fsel;
    logic         ordy;

    int compared   = 0;
    int mismatched = 0;

    int m_valid[2];
    int m_data[2];
    int m_sel[2];
    int m_ptr[2];

    rr_arb_mux_if #(.NUM_CH(N), .DATA_W(W)) rr_bus ();
    rr_arb_mux_if #(.NUM_CH(N), .DATA_W(W)) fx_bus ();

    assign rr_bus.in_data   = din;
    assign rr_bus.in_valid  = vin;
    assign rr_bus.force_en  = fen;
    assign rr_bus.force_sel = fsel;
    assign rr_bus.out_ready = ordy;
    assign fx_bus.in_data   = din;
    assign fx_bus.in_valid  = vin;
    assign fx_bus.force_en  = fen;
    assign fx_bus.force_sel = fsel;
    assign fx_bus.out_ready = ordy;

    rr_arb_mux #(.NUM_CH(N), .DATA_W(W), .ARB_MODE(0)) u_rr (.clk(clk), .rst(rst), .bus(rr_bus));
    rr_arb_mux #(.NUM_CH(N), .DATA_W(W), .ARB_MODE(1)) u_fx (.clk(clk), .rst(rst), .bus(fx_bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner = eligible channel at the smallest round-robin distance from ptr
    // (mode 0) or the smallest index (mode 1); -1 when nothing is eligible.
    function automatic int pick(input int mode, input int ptr);
        int best = -1;
        int bd   = N + 1;
        int d;
        for (int ch = 0; ch < N; ch++) begin
            if (vin[ch] && (!fen || int'(fsel) == ch)) begin
                d = (mode == 0) ? (ch - ptr + N) % N : ch;
                if (d < bd) begin
                    bd   = d;
                    best = ch;
                end
            end
        end
        return best;
    endfunction

    task automatic cycle();
        int g[2];
        int exp_rdy;
        #2;
        for (int m = 0; m < 2; m++) begin
            g[m]    = pick(m, m_ptr[m]);
            exp_rdy = (!rst && (m_valid[m] == 0 || ordy) && g[m] >= 0) ? (1 << g[m]) : 0;
            chk($sformatf("%s in_ready", m ? "fx" : "rr"),
                m ? 32'(fx_bus.in_ready) : 32'(rr_bus.in_ready), exp_rdy);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
            end else if (m_valid[m] == 0 || ordy) begin
                if (g[m] >= 0) begin
                    m_data[m]  = int'(din[8*g[m] +: 8]);
                    m_sel[m]   = g[m];
                    m_valid[m] = 1;
                    if (m == 0 && !fen) m_ptr[m] = (g[m] + 1) % N;
                end else begin
                    m_valid[m] = 0;
                end
            end
        end
        #1;
        chk("rr out_valid", 32'(rr_bus.out_valid), m_valid[0]);
        chk("rr out_data",  32'(rr_bus.out_data),  m_data[0]);
        chk("rr out_sel",   32'(rr_bus.out_sel),   m_sel[0]);
        chk("fx out_valid", 32'(fx_bus.out_valid), m_valid[1]);
        chk("fx out_data",  32'(fx_bus.out_data),  m_data[1]);
        chk("fx out_sel",   32'(fx_bus.out_sel),   m_sel[1]);
    endtask

    initial begin
        logic [7:0] rr_seq [5];
        rr_seq = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0; m_ptr[m] = 0;
        end
        din = 32'hD3C2B1A0; vin = 4'hF; fen = 1'b0; fsel = 2'd0; ordy = 1'b1; rst = 1'b1;

        // reset with all channels valid
        repeat (2) cycle();
        chk("reset out_valid", 32'(rr_bus.out_valid), 0);
        chk("reset out_data",  32'(rr_bus.out_data), 0);

        // round-robin rotation
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr rotate data", 32'(rr_bus.out_data), 32'(rr_seq[i]));
            chk("fx repeat data", 32'(fx_bus.out_data), 32'hA0);
        end

        // backpressure while B1 is held
        cycle();
        ordy = 1'b0;
        repeat (3) begin
            cycle();
            chk("hold data", 32'(rr_bus.out_data), 32'hB1);
            chk("hold sel",  32'(rr_bus.out_sel), 1);
        end
        ordy = 1'b1;
        cycle();
        chk("release data", 32'(rr_bus.out_data), 32'hC2);

        // sparse requests from ptr=2
        vin = 4'b0010; cycle();
        vin = 4'b1010;
        cycle(); chk("sparse first",  32'(rr_bus.out_data), 32'hD3);
        cycle(); chk("sparse second", 32'(rr_bus.out_data), 32'hB1);
        vin = 4'b0000;
        cycle(); chk("idle valid", 32'(rr_bus.out_valid), 0);

        // forced select
        vin = 4'hF; fen = 1'b1; fsel = 2'd2;
        repeat (3) begin
            cycle();
            chk("force data",     32'(rr_bus.out_data), 32'hC2);
            chk("force in_ready", 32'(rr_bus.in_ready), 32'b0100);
        end
        fen = 1'b0;
        cycle(); chk("unforce first",  32'(rr_bus.out_data), 32'hC2);
        cycle(); chk("unforce second", 32'(rr_bus.out_data), 32'hD3);

        // fixed priority falls to next index
        vin = 4'b1110;
        cycle(); chk("fx next", 32'(fx_bus.out_data), 32'hB1);

        // reset while a word is stalled
        vin = 4'hF; ordy = 1'b0;
        cycle();
        rst = 1'b1;
        cycle(); chk("midrst valid", 32'(rr_bus.out_valid), 0);
        rst = 1'b0; ordy = 1'b1;
        cycle(); chk("post rst sel", 32'(rr_bus.out_sel), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            din  = $urandom;
            vin  = 4'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 3) != 0);
            fen  = ($urandom_range(0, 7) == 0);
            fsel = 2'($urandom_range(0, 3));
            rst  = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
